// File: rtl/ser_irq_stat_if.sv
// CPU register-port bundle for the serial/keyboard IRQ status block.
// Signal names match the original flat ports so call sites map one-to-one.
interface ser_irq_stat_if;
  logic [7:0] Dw;
  logic       IrqenWr;
  logic       SkresWr;
  logic [7:0] Irqst;
  logic [7:0] Skstat;
  logic       nIRQ;

  modport master (
    output Dw, IrqenWr, SkresWr,
    input  Irqst, Skstat, nIRQ
  );

  modport slave (
    input  Dw, IrqenWr, SkresWr,
    output Irqst, Skstat, nIRQ
  );
endinterface

// File: rtl/ser_irq_stat.sv
// IRQEN/IRQST interrupt latching plus SKSTAT sticky error flags for the serial/keyboard core.
// All state advances only on rising clk qualified by enp.
module ser_irq_stat (
  input  logic           clk,
  input  logic           reset,
  input  logic           enp,
  input  logic           setSdiCompl,
  input  logic           setFramerr,
  input  logic           setSdoCompl,
  input  logic           sdoFinish,
  input  logic           sdiBusy,
  input  logic           SID,
  input  logic           Timer1,
  input  logic           Timer2,
  input  logic           Timer4,
  input  logic           kbIrq,
  input  logic           brkIrq,
  input  logic           kbOverSet,
  input  logic           shiftKey,
  input  logic           keyDown,
  ser_irq_stat_if.slave  bus
);

  logic [7:0] irq_en_q, irq_en_d;
  logic [7:0] pend_q,   pend_d;
  logic       frm_err_q, frm_err_d;
  logic       sdi_ovr_q, sdi_ovr_d;
  logic       kb_ovr_q,  kb_ovr_d;

  logic [7:0] src;
  logic [7:0] en_eff;
  logic       sdo_irq;

  assign src = {brkIrq, kbIrq, setSdiCompl, setSdoCompl, 1'b0, Timer4, Timer2, Timer1};

  // A same-cycle IRQEN write already governs which pulses may latch.
  assign en_eff = bus.IrqenWr ? bus.Dw : irq_en_q;

  always_comb begin
    irq_en_d  = irq_en_q;
    pend_d    = pend_q;
    frm_err_d = frm_err_q;
    sdi_ovr_d = sdi_ovr_q;
    kb_ovr_d  = kb_ovr_q;
    if (enp) begin
      if (bus.IrqenWr) begin
        irq_en_d = bus.Dw;
        pend_d   = pend_q & bus.Dw;
      end
      pend_d    = pend_d | (src & en_eff);
      pend_d[3] = 1'b0;
      // Clear first, then set, so a coincident set survives SKRES.
      if (bus.SkresWr) begin
        frm_err_d = 1'b0;
        sdi_ovr_d = 1'b0;
        kb_ovr_d  = 1'b0;
      end
      if (setFramerr)                frm_err_d = 1'b1;
      if (setSdiCompl && pend_q[5])  sdi_ovr_d = 1'b1;
      if (kbOverSet)                 kb_ovr_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_q  <= '0;
      pend_q    <= '0;
      frm_err_q <= 1'b0;
      sdi_ovr_q <= 1'b0;
      kb_ovr_q  <= 1'b0;
    end else begin
      irq_en_q  <= irq_en_d;
      pend_q    <= pend_d;
      frm_err_q <= frm_err_d;
      sdi_ovr_q <= sdi_ovr_d;
      kb_ovr_q  <= kb_ovr_d;
    end
  end

  // Bit 3 is a live level, never latched.
  assign sdo_irq = sdoFinish & irq_en_q[3];

  always_comb begin
    bus.Irqst    = ~pend_q;
    bus.Irqst[3] = ~sdo_irq;
  end

  assign bus.Skstat = {~frm_err_q, ~kb_ovr_q, ~sdi_ovr_q, SID, ~shiftKey, ~keyDown, sdiBusy, 1'b1};
  assign bus.nIRQ   = ~((|pend_q) | sdo_irq);

endmodule

// File: tb/tb_ser_irq_stat.sv
// Scoreboard bench for ser_irq_stat: directed scenarios then a randomized run against a reference model.
module tb_ser_irq_stat;

  logic clk = 1'b0;
  logic reset, enp;
  logic setSdiCompl, setFramerr, setSdoCompl, sdoFinish, sdiBusy, SID;
  logic Timer1, Timer2, Timer4, kbIrq, brkIrq, kbOverSet, shiftKey, keyDown;

  ser_irq_stat_if bus ();

  ser_irq_stat dut (
    .clk         (clk),
    .reset       (reset),
    .enp         (enp),
    .setSdiCompl (setSdiCompl),
    .setFramerr  (setFramerr),
    .setSdoCompl (setSdoCompl),
    .sdoFinish   (sdoFinish),
    .sdiBusy     (sdiBusy),
    .SID         (SID),
    .Timer1      (Timer1),
    .Timer2      (Timer2),
    .Timer4      (Timer4),
    .kbIrq       (kbIrq),
    .brkIrq      (brkIrq),
    .kbOverSet   (kbOverSet),
    .shiftKey    (shiftKey),
    .keyDown     (keyDown),
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] irqst;
    logic [7:0] skstat;
    logic       nirq;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // reference model state for the randomized phase
  logic [7:0] m_en, m_pend;
  logic       m_frm, m_sdi, m_kb;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] irq, input logic [7:0] sk, input logic n);
    exp_t e;
    e.tag = tag; e.irqst = irq; e.skstat = sk; e.nirq = n;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    check("sb_nonempty", {7'b0, (sb.size() != 0)}, 8'h01);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, ".Irqst"},  bus.Irqst,         e.irqst);
      check({e.tag, ".Skstat"}, bus.Skstat,        e.skstat);
      check({e.tag, ".nIRQ"},   {7'b0, bus.nIRQ},  {7'b0, e.nirq});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic settle();
    #1;
    compare_out();
  endtask

  task automatic clear_pulses();
    setSdiCompl = 0; setFramerr = 0; setSdoCompl = 0;
    Timer1 = 0; Timer2 = 0; Timer4 = 0;
    kbIrq = 0; brkIrq = 0; kbOverSet = 0;
    bus.IrqenWr = 0; bus.SkresWr = 0; bus.Dw = '0;
  endtask

  task automatic rand_step(input int unsigned idx);
    logic [7:0] src, nxt, irq, sk;
    logic       eff, n;
    enp         = ($urandom_range(0, 3) != 0);
    setSdiCompl = ($urandom_range(0, 3) == 0);
    setFramerr  = ($urandom_range(0, 7) == 0);
    setSdoCompl = ($urandom_range(0, 3) == 0);
    Timer1      = ($urandom_range(0, 3) == 0);
    Timer2      = ($urandom_range(0, 3) == 0);
    Timer4      = ($urandom_range(0, 3) == 0);
    kbIrq       = ($urandom_range(0, 3) == 0);
    brkIrq      = ($urandom_range(0, 3) == 0);
    kbOverSet   = ($urandom_range(0, 7) == 0);
    bus.IrqenWr = ($urandom_range(0, 5) == 0);
    bus.SkresWr = ($urandom_range(0, 5) == 0);
    bus.Dw      = 8'($urandom_range(0, 255));
    sdoFinish   = $urandom_range(0, 1) != 0;
    sdiBusy     = $urandom_range(0, 1) != 0;
    SID         = $urandom_range(0, 1) != 0;
    shiftKey    = $urandom_range(0, 1) != 0;
    keyDown     = $urandom_range(0, 1) != 0;
    if (enp) begin
      src = {brkIrq, kbIrq, setSdiCompl, setSdoCompl, 1'b0, Timer4, Timer2, Timer1};
      nxt = m_pend;
      for (int unsigned i = 0; i < 8; i++) begin
        eff = bus.IrqenWr ? bus.Dw[i] : m_en[i];
        if (bus.IrqenWr && !bus.Dw[i]) nxt[i] = 1'b0;
        if (i != 3 && src[i] && eff) nxt[i] = 1'b1;
      end
      m_frm = (bus.SkresWr ? 1'b0 : m_frm) | setFramerr;
      m_kb  = (bus.SkresWr ? 1'b0 : m_kb)  | kbOverSet;
      m_sdi = (bus.SkresWr ? 1'b0 : m_sdi) | (setSdiCompl & m_pend[5]);
      m_pend = nxt;
      if (bus.IrqenWr) m_en = bus.Dw;
    end
    irq    = ~m_pend;
    irq[3] = ~(sdoFinish & m_en[3]);
    sk     = {~m_frm, ~m_kb, ~m_sdi, SID, ~shiftKey, ~keyDown, sdiBusy, 1'b1};
    n      = ~((|m_pend) | (sdoFinish & m_en[3]));
    expect_out($sformatf("rand%0d", idx), irq, sk, n);
    tick();
  endtask

  initial begin
    reset = 1; enp = 1; sdoFinish = 0;
    SID = 1; shiftKey = 1; keyDown = 0; sdiBusy = 1;
    clear_pulses();

    // Skstat base with these levels and no sticky flags: F7
    expect_out("reset", 8'hFF, 8'hF7, 1'b1); settle();
    @(negedge clk); reset = 0;

    // IRQEN=20, serial-in complete
    bus.IrqenWr = 1; bus.Dw = 8'h20;
    expect_out("en20", 8'hFF, 8'hF7, 1'b1); tick();
    clear_pulses(); setSdiCompl = 1;
    expect_out("sdi1", 8'hDF, 8'hF7, 1'b0); tick();

    // overrun then SKRES
    expect_out("sdi_ovr", 8'hDF, 8'hD7, 1'b0); tick();
    clear_pulses(); bus.SkresWr = 1;
    expect_out("skres", 8'hDF, 8'hF7, 1'b0); tick();

    // enp low: everything ignored
    clear_pulses(); enp = 0; setFramerr = 1; bus.IrqenWr = 1; bus.Dw = 8'h00; kbOverSet = 1;
    expect_out("enp0", 8'hDF, 8'hF7, 1'b0); tick();
    clear_pulses(); enp = 1;

    // disabled source is dropped, not remembered
    bus.IrqenWr = 1; bus.Dw = 8'h00;
    expect_out("en00", 8'hFF, 8'hF7, 1'b1); tick();
    clear_pulses(); Timer1 = 1;
    expect_out("t1_masked", 8'hFF, 8'hF7, 1'b1); tick();
    clear_pulses(); bus.IrqenWr = 1; bus.Dw = 8'h01;
    expect_out("en01_nopulse", 8'hFF, 8'hF7, 1'b1); tick();

    // bit 3 level path
    bus.Dw = 8'h08;
    expect_out("en08", 8'hFF, 8'hF7, 1'b1); tick();
    clear_pulses(); sdoFinish = 1;
    expect_out("sdo_fin1", 8'hF7, 8'hF7, 1'b0); settle();
    sdoFinish = 0;
    expect_out("sdo_fin0", 8'hFF, 8'hF7, 1'b1); settle();

    // same-cycle set vs clear
    bus.SkresWr = 1; setFramerr = 1;
    expect_out("skres_vs_frm", 8'hFF, 8'h77, 1'b1); tick();
    clear_pulses(); bus.IrqenWr = 1; bus.Dw = 8'h02;
    expect_out("en02", 8'hFF, 8'h77, 1'b1); tick();
    bus.Dw = 8'h00; Timer2 = 1;
    expect_out("wr00_vs_t2", 8'hFF, 8'h77, 1'b1); tick();
    bus.Dw = 8'h02;
    expect_out("wr02_with_t2", 8'hFD, 8'h77, 1'b0); tick();
    clear_pulses(); kbOverSet = 1;
    expect_out("kbovr", 8'hFD, 8'h37, 1'b0); tick();
    clear_pulses(); bus.SkresWr = 1;
    expect_out("skres2", 8'hFD, 8'hF7, 1'b0); tick();

    // pend=F7 then async reset between edges
    clear_pulses(); bus.IrqenWr = 1; bus.Dw = 8'hF7;
    Timer1 = 1; Timer2 = 1; Timer4 = 1; setSdoCompl = 1; setSdiCompl = 1; kbIrq = 1; brkIrq = 1;
    expect_out("pend_f7", 8'h08, 8'hF7, 1'b0); tick();
    clear_pulses();
    @(negedge clk); #2 reset = 1;
    expect_out("async_rst", 8'hFF, 8'hF7, 1'b1); settle();
    bus.IrqenWr = 1; bus.Dw = 8'hFF; Timer1 = 1;
    expect_out("rst_held", 8'hFF, 8'hF7, 1'b1); tick();
    @(negedge clk); reset = 0;
    bus.Dw = 8'h01;
    expect_out("post_rst", 8'hFE, 8'hF7, 1'b0); tick();

    // randomized run against the model
    clear_pulses();
    @(negedge clk); reset = 1;
    expect_out("rand_rst", 8'hFF, 8'hF7, 1'b1); settle();
    m_en = '0; m_pend = '0; m_frm = 0; m_sdi = 0; m_kb = 0;
    @(negedge clk); reset = 0;
    for (int unsigned k = 0; k < 400; k++) rand_step(k);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ser_irq_stat.md
SER_IRQ_STAT -- requirements
Module: ser_irq_stat

Interface
REQ-001 The module SHALL have these ports:
  - clk  input  1  system clock.
  - reset  input  1  asynchronous, active-high reset.
  - enp  input  1  positive-phase clock enable; state updates only on rising clk with enp=1.
  - setSdiCompl  input  1  serial-in byte-complete pulse from the serial core.
  - setFramerr  input  1  serial-in framing-error pulse.
  - setSdoCompl  input  1  serial-out holding register empty ("output needed") pulse.
  - sdoFinish  input  1  level, serial-out shifter idle.
  - sdiBusy  input  1  level, active-low serial-in busy.
  - SID  input  1  raw serial input pin.
  - Timer1, Timer2, Timer4  input  1 each  timer underflow pulses.
  - kbIrq, brkIrq, kbOverSet  input  1 each  keyboard-scan event pulses.
  - shiftKey, keyDown  input  1 each  keyboard levels.
  - Dw  input  8  CPU write data.
  - IrqenWr  input  1  write strobe, IRQEN.
  - SkresWr  input  1  write strobe, SKRES.
  - Irqst  output  8  IRQST read value, active-low bits.
  - Skstat  output  8  SKSTAT read value.
  - nIRQ  output  1  active-low CPU interrupt.

Function
REQ-002 The module SHALL hold registers irqEn[7:0], pend[7:0] (bit 3 unused), frmErr, sdiOvr and kbOvr.
REQ-003 Pending-bit sources SHALL be mapped as:
  - bit 0 = Timer1, bit 1 = Timer2, bit 2 = Timer4.
  - bit 4 = setSdoCompl, bit 5 = setSdiCompl.
  - bit 6 = kbIrq, bit 7 = brkIrq.
REQ-004 On an enp cycle, pend[n] SHALL set to 1 when its source pulse is 1 and the effective enable for bit n is 1.
REQ-005 The effective enable SHALL be Dw[n] if IrqenWr=1 in that cycle, otherwise irqEn[n].
REQ-006 IrqenWr=1 SHALL load irqEn<=Dw and clear every pend[n] whose new Dw[n]=0 in the same cycle.
REQ-007 A source pulse SHALL NOT set pend[n] while irqEn[n]=0, and the dropped event SHALL NOT be remembered.
REQ-008 pend bits SHALL clear only via REQ-006 or reset; pend[n] stays 1 across repeated source pulses.
REQ-009 Irqst[n] SHALL equal ~pend[n] for n != 3.
REQ-010 Irqst[3] SHALL equal ~(sdoFinish & irqEn[3]); bit 3 is unlatched, level-sensitive.
REQ-011 Overrun: if setSdiCompl=1 while pend[5] is already 1 (pre-update value), sdiOvr SHALL set to 1.
REQ-012 setFramerr=1 SHALL set frmErr to 1.
REQ-013 kbOverSet=1 SHALL set kbOvr to 1.
REQ-014 SkresWr=1 SHALL clear frmErr, sdiOvr and kbOvr.
REQ-015 If SkresWr and a set condition occur in the same cycle, set SHALL win for that flag.
REQ-016 Skstat bit mapping SHALL be:
  - bit 7 = ~frmErr.
  - bit 6 = ~kbOvr.
  - bit 5 = ~sdiOvr.
  - bit 4 = SID.
  - bit 3 = ~shiftKey.
  - bit 2 = ~keyDown.
  - bit 1 = sdiBusy.
  - bit 0 = 1.
REQ-017 nIRQ SHALL equal ~(|pend | (sdoFinish & irqEn[3])), combinational from registers and sdoFinish.
REQ-018 Register latency from event pulse to Irqst/Skstat/nIRQ change SHALL be exactly one enp edge; no additional pipeline stage is permitted.
REQ-019 All register updates SHALL be ignored when enp=0; the input pulses are guaranteed by the upstream core to be held through an enp edge.

Reset
REQ-020 While reset=1, irqEn, pend, frmErr, sdiOvr and kbOvr SHALL be 0 immediately, regardless of clk/enp.
REQ-021 Reset values of outputs SHALL be:
  - Irqst = 8'hFF.
  - nIRQ = 1.
  - Skstat = {1,1,1,SID,~shiftKey,~keyDown,sdiBusy,1}.
REQ-022 Reset asserted mid-operation SHALL discard all pending/sticky state; the first enp edge after deassertion SHALL process inputs normally.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  - Write IRQEN=8'h20, pulse setSdiCompl -> Irqst=8'hDF, nIRQ=0 after one enp edge.
  - With pend[5]=1, pulse setSdiCompl again -> Skstat[5]=0; write SKRES -> Skstat[5]=1, Irqst still 8'hDF.
  - IRQEN=8'h00, pulse Timer1 -> Irqst=8'hFF, nIRQ=1; then write IRQEN=8'h01 with no pulse -> Irqst stays 8'hFF.
  - IRQEN=8'h08, sdoFinish=1 -> Irqst=8'hF7, nIRQ=0; sdoFinish=0 -> Irqst=8'hFF with no write.
  - Same-cycle SkresWr=1 and setFramerr=1 -> Skstat[7]=0; same-cycle IrqenWr (Dw=8'h00) and Timer2 -> Irqst=8'hFF.
  - pend=8'hF7, assert reset asynchronously between edges -> Irqst=8'hFF, nIRQ=1 before next clk edge.
